mul_unit: RTL

- Iterative integer multiplier for the scalar execute stage; the multiply counterpart of the iterative divider.
- Implements RV64 MUL, MULH, MULHSU, MULHU and MULW using the same request/stall/kill handshake as the divider.
- Processes 4 multiplier bits per cycle on operand magnitudes, then applies sign correction.
- Operands and control are latched at acceptance, so the issuing stage does not have to hold them.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_4bits.sv | 28 ++
 rtl/mul_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: op encodings, FSM states,
// iteration counts and the operand magnitude helper.
package mul_pkg;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned DIGIT_W = 4;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   localparam logic [3:0] ITER_64 = 4'd15;
   localparam logic [3:0] ITER_32 = 4'd7;

   typedef enum logic [1:0] {
      IDLE,
      OP,
      DONE
   } mul_state_e;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/mul_4bits.sv
// One radix-16 step of the magnitude multiplier: adds mcand * mplier[3:0] into
// the accumulator and advances both operands by one digit.
module mul_4bits
   import mul_pkg::*;
(
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [2*XLEN-1:0] mcand_i,
   input  logic [XLEN-1:0]   mplier_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [2*XLEN-1:0] mcand_o,
   output logic [XLEN-1:0]   mplier_o
);

   logic [2*XLEN-1:0] pp;

   always_comb begin
      pp = '0;
      for (int unsigned i = 0; i < DIGIT_W; i++) begin
         if (mplier_i[i]) begin
            pp = pp + (mcand_i << i);
         end
      end
      acc_o    = acc_i + pp;
      mcand_o  = mcand_i << DIGIT_W;
      mplier_o = mplier_i >> DIGIT_W;
   end

endmodule

// File: rtl/mul_unit.sv
// Iterative RV64 multiplier (MUL/MULH/MULHSU/MULHU/MULW) with request/stall/kill
// handshake. Define MUL_EARLY_OUT_EN to finish as soon as the multiplier runs out.
module mul_unit
   import mul_pkg::*;
(
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        kill_mul_i,
   input  logic        request_i,
   input  logic        int_32_i,
   input  logic [1:0]  op_i,
   input  logic [63:0] src1_i,
   input  logic [63:0] src2_i,
   output logic [63:0] result_o,
   output logic        done_o,
   output logic        stall_o
);

   mul_state_e        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic              int32_q, int32_d;
   logic              neg_q, neg_d;
   logic [3:0]        n_q, n_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;

   logic [2*XLEN-1:0] step_acc, step_mcand;
   logic [XLEN-1:0]   step_mplier;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   a_ext, b_ext;
   logic              a_signed, b_signed;
   logic              early_done;

   mul_4bits u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (step_acc),
      .mcand_o  (step_mcand),
      .mplier_o (step_mplier)
   );

`ifdef MUL_EARLY_OUT_EN
   assign early_done = (step_mplier == '0);
`else
   assign early_done = 1'b0;
`endif

   // MULW treats both operands as signed 32-bit values regardless of op_i
   always_comb begin
      a_signed = int_32_i | (op_i != MUL_OP_MULHU);
      b_signed = int_32_i | (op_i == MUL_OP_MUL) | (op_i == MUL_OP_MULH);
      a_ext    = int_32_i ? {{32{src1_i[31]}}, src1_i[31:0]} : src1_i;
      b_ext    = int_32_i ? {{32{src2_i[31]}}, src2_i[31:0]} : src2_i;
      prod     = neg_q ? -acc_q : acc_q;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      int32_d  = int32_q;
      neg_d    = neg_q;
      n_d      = n_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      stall_o  = 1'b0;
      done_o   = 1'b0;
      result_o = '0;
      unique case (state_q)
         IDLE: begin
            if (request_i && !kill_mul_i) begin
               stall_o  = 1'b1;
               op_d     = op_i;
               int32_d  = int_32_i;
               neg_d    = (a_signed & a_ext[XLEN-1]) ^ (b_signed & b_ext[XLEN-1]);
               acc_d    = '0;
               mcand_d  = {{XLEN{1'b0}}, mag(a_ext, a_signed)};
               mplier_d = mag(b_ext, b_signed);
               n_d      = int_32_i ? ITER_32 : ITER_64;
               state_d  = OP;
            end
         end
         OP: begin
            if (kill_mul_i) begin
               state_d = IDLE;
            end else begin
               stall_o  = 1'b1;
               acc_d    = step_acc;
               mcand_d  = step_mcand;
               mplier_d = step_mplier;
               if (n_q == 4'd0 || early_done) begin
                  state_d = DONE;
               end else begin
                  n_d = n_q - 4'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!kill_mul_i) begin
               done_o = 1'b1;
               if (int32_q) begin
                  result_o = {{32{prod[31]}}, prod[31:0]};
               end else if (op_q == MUL_OP_MUL) begin
                  result_o = prod[XLEN-1:0];
               end else begin
                  result_o = prod[2*XLEN-1:XLEN];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         op_q     <= '0;
         int32_q  <= 1'b0;
         neg_q    <= 1'b0;
         n_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         int32_q  <= int32_d;
         neg_q    <= neg_d;
         n_q      <= n_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule
